// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and address helpers for the burst generator and
// future subordinate models.
package ahb_pkg;

  typedef enum logic [1:0] {
    AHB_IDLE   = 2'b00,
    AHB_BUSY   = 2'b01,
    AHB_NONSEQ = 2'b10,
    AHB_SEQ    = 2'b11
  } ahb_trans_t;

  typedef enum logic [2:0] {
    AHB_SIZE_8    = 3'd0,
    AHB_SIZE_16   = 3'd1,
    AHB_SIZE_32   = 3'd2,
    AHB_SIZE_64   = 3'd3,
    AHB_SIZE_128  = 3'd4,
    AHB_SIZE_256  = 3'd5,
    AHB_SIZE_512  = 3'd6,
    AHB_SIZE_1024 = 3'd7
  } ahb_size_t;

  typedef enum logic [2:0] {
    AHB_SINGLE = 3'd0,
    AHB_INCR   = 3'd1,
    AHB_WRAP4  = 3'd2,
    AHB_INCR4  = 3'd3,
    AHB_WRAP8  = 3'd4,
    AHB_INCR8  = 3'd5,
    AHB_WRAP16 = 3'd6,
    AHB_INCR16 = 3'd7
  } ahb_burst_t;

  typedef enum logic {
    AHB_OKAY  = 1'b0,
    AHB_ERROR = 1'b1
  } ahb_resp_t;

  localparam int unsigned AHB_1KB_BOUNDARY = 1024;

  // Helpers work on the widest address any instance may use; callers slice.
  localparam int unsigned AHB_ADDR_MAX = 64;
  typedef logic [AHB_ADDR_MAX-1:0] ahb_addr_t;

  function automatic logic ahb_is_wrap(ahb_burst_t burst);
    return burst inside {AHB_WRAP4, AHB_WRAP8, AHB_WRAP16};
  endfunction

  function automatic int unsigned ahb_burst_beats(ahb_burst_t burst, int unsigned len);
    case (burst)
      AHB_INCR:              return len + 1;
      AHB_WRAP4, AHB_INCR4:  return 4;
      AHB_WRAP8, AHB_INCR8:  return 8;
      AHB_WRAP16, AHB_INCR16: return 16;
      default:               return 1;
    endcase
  endfunction

  function automatic ahb_addr_t ahb_next_addr(ahb_addr_t addr, ahb_size_t size, ahb_burst_t burst);
    ahb_addr_t inc;
    ahb_addr_t mask;
    inc  = ahb_addr_t'(1) << size;
    mask = '0;
    case (burst)
      AHB_WRAP4:  mask = (inc << 2) - ahb_addr_t'(1);
      AHB_WRAP8:  mask = (inc << 3) - ahb_addr_t'(1);
      AHB_WRAP16: mask = (inc << 4) - ahb_addr_t'(1);
      default:    mask = '0;
    endcase
    if (ahb_is_wrap(burst))
      return (addr & ~mask) | ((addr + inc) & mask);
    return addr + inc;
  endfunction

endpackage

// File: rtl/ahb_addr_inc.sv
// Combinational next-beat address: increment or wrap, plus a flag when an
// incrementing burst steps into a new 1 KB page.
module ahb_addr_inc
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  ahb_size_t             size,
  input  ahb_burst_t            burst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  cross_1kb
);

  localparam int KB_BIT = $clog2(AHB_1KB_BOUNDARY);
  // Truncation to ADDR_WIDTH gives modulo-2^ADDR_WIDTH behaviour for INCR.
  localparam ahb_addr_t AW_MASK = (ahb_addr_t'(1) << ADDR_WIDTH) - ahb_addr_t'(1);

  ahb_addr_t addr_ext;
  ahb_addr_t next_ext;
  ahb_addr_t next_trunc;

  always_comb begin
    addr_ext                   = '0;
    addr_ext[ADDR_WIDTH-1:0]   = addr;
    next_ext                   = ahb_next_addr(addr_ext, size, burst);
    next_trunc                 = next_ext & AW_MASK;
    next_addr                  = next_trunc[ADDR_WIDTH-1:0];
    cross_1kb                  = !ahb_is_wrap(burst) && (burst != AHB_SINGLE) &&
                                 ((addr_ext >> KB_BIT) != (next_trunc >> KB_BIT));
  end

endmodule

// File: rtl/ahb_burst_gen.sv
// AHB-Lite manager address-phase engine: one command in, one full burst out.
// Define AHB_BURST_GEN_1KB_SPLIT_EN to reissue INCR beats as NONSEQ at 1 KB pages.
module ahb_burst_gen
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [2:0]            cmd_burst_i,
  input  logic [2:0]            cmd_size_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic                  cmd_write_i,
  output logic [ADDR_WIDTH-1:0] haddr_o,
  output logic [1:0]            htrans_o,
  output logic [2:0]            hburst_o,
  output logic [2:0]            hsize_o,
  output logic                  hwrite_o,
  input  logic                  hready_i,
  input  logic                  hresp_i,
  output logic                  beat_done_o,
  output logic                  beat_last_o,
  output logic                  err_o
);

  localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);
  localparam int BEAT_W   = (LEN_WIDTH + 1 > 5) ? LEN_WIDTH + 1 : 5;

`ifdef AHB_BURST_GEN_1KB_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t            state;
  ahb_trans_t        htrans_q;
  ahb_burst_t        hburst_q;
  ahb_size_t         hsize_q;
  logic [BEAT_W-1:0] beats_left;
  logic              dp_valid;
  logic              dp_last;

  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  cross_1kb;
  logic                  addr_acc;
  logic                  last_acc;
  logic                  err_hit;
  logic                  cmd_fire;
  logic                  size_ok;
  logic                  dp_ok;

  ahb_addr_inc #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_inc (
    .addr      (haddr_o),
    .size      (hsize_q),
    .burst     (hburst_q),
    .next_addr (next_addr),
    .cross_1kb (cross_1kb)
  );

  always_comb begin
    addr_acc    = (htrans_q != AHB_IDLE) && hready_i;
    last_acc    = addr_acc && (beats_left == BEAT_W'(1));
    // First ERROR cycle: HREADY low with HRESP already ERROR.
    err_hit     = dp_valid && (hresp_i == AHB_ERROR) && !hready_i;
    cmd_ready_o = !err_hit && ((state == ST_IDLE) || ((state == ST_ADDR) && last_acc));
    cmd_fire    = cmd_valid_i && cmd_ready_o;
    size_ok     = int'(cmd_size_i) <= MAX_SIZE;
    dp_ok       = dp_valid && hready_i && (hresp_i == AHB_OKAY);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      haddr_o     <= '0;
      htrans_q    <= AHB_IDLE;
      hburst_q    <= AHB_SINGLE;
      hsize_q     <= AHB_SIZE_8;
      hwrite_o    <= 1'b0;
      beats_left  <= '0;
      dp_valid    <= 1'b0;
      dp_last     <= 1'b0;
      beat_done_o <= 1'b0;
      beat_last_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      beat_done_o <= dp_ok;
      beat_last_o <= dp_ok && dp_last;
      err_o       <= 1'b0;
      if (hready_i) begin
        dp_valid <= addr_acc;
        dp_last  <= last_acc;
      end

      if (err_hit) begin
        // Drop the rest of the burst; the errored beat never reports done.
        state      <= ST_ERR;
        htrans_q   <= AHB_IDLE;
        beats_left <= '0;
        dp_valid   <= 1'b0;
        err_o      <= 1'b1;
      end else begin
        case (state)
          ST_IDLE, ST_ADDR: begin
            if (cmd_fire) begin
              if (size_ok) begin
                state      <= ST_ADDR;
                haddr_o    <= cmd_addr_i;
                htrans_q   <= AHB_NONSEQ;
                hburst_q   <= ahb_burst_t'(cmd_burst_i);
                hsize_q    <= ahb_size_t'(cmd_size_i);
                hwrite_o   <= cmd_write_i;
                beats_left <= BEAT_W'(ahb_burst_beats(ahb_burst_t'(cmd_burst_i), 32'(cmd_len_i)));
              end else begin
                state      <= ST_IDLE;
                htrans_q   <= AHB_IDLE;
                beats_left <= '0;
                err_o      <= 1'b1;
              end
            end else if (last_acc) begin
              state      <= ST_IDLE;
              htrans_q   <= AHB_IDLE;
              beats_left <= '0;
            end else if (addr_acc) begin
              haddr_o    <= next_addr;
              beats_left <= beats_left - BEAT_W'(1);
              if (SPLIT_EN && cross_1kb) begin
                htrans_q <= AHB_NONSEQ;
                hburst_q <= AHB_INCR;
              end else begin
                htrans_q <= AHB_SEQ;
              end
            end
          end
          ST_ERR: begin
            if (hready_i) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign htrans_o = htrans_q;
  assign hburst_o = hburst_q;
  assign hsize_o  = hsize_q;

endmodule
